kronos_hazard_tracker: RTL and testbench



---
 rtl/kronos_hazard_tracker.sv | 118 +++++++++++
 tb/tb_kronos_hazard_tracker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_hazard_tracker.sv
// kronos_hazard_tracker: per-register pending-write scoreboard for the decode
// stage. Each architectural register carries a DEPTH-bit thermometer count of
// in-flight writes. Decode raises a stall when it reads a register that still
// has a write pending. The stall is masked when the single remaining write is
// being committed on the write-back bus in the same cycle, so the operand can
// be forwarded instead.
module kronos_hazard_tracker #(
    parameter int NREG    = 32,
    parameter int DEPTH   = 2,
    parameter int FWD_EN  = 1,
    parameter int X0_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rstz,
    input  logic                    flush,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    input  logic                    regrd_rs1_en,
    input  logic                    regrd_rs2_en,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic                    upgrade,
    input  logic [$clog2(NREG)-1:0] regwr_sel,
    input  logic                    downgrade,
    output logic                    stall,
    output logic                    fwd_rs1,
    output logic                    fwd_rs2,
    output logic                    pending_any,
    output logic                    err_overflow,
    output logic                    err_underflow
);

    localparam int IW = $clog2(NREG);

    logic [NREG-1:0][DEPTH-1:0] lvl;
    logic [NREG-1:0][DEPTH-1:0] lvl_nxt;
    logic                       ovf_nxt;
    logic                       unf_nxt;
    logic                       up_eff;
    logic                       dn_eff;
    logic                       haz1;
    logic                       haz2;
    logic [NREG-1:0]            busy;

    // One more pending write: shift a 1 into the thermometer, saturating at full.
    function automatic logic [DEPTH-1:0] lvl_up(input logic [DEPTH-1:0] v);
        return (v << 1) | DEPTH'(1);
    endfunction

    // One fewer pending write: shift the thermometer down, saturating at empty.
    function automatic logic [DEPTH-1:0] lvl_dn(input logic [DEPTH-1:0] v);
        return v >> 1;
    endfunction

    // True when two or more writes are pending; always false for DEPTH=1.
    function automatic logic lvl_deep(input logic [DEPTH-1:0] v);
        logic [DEPTH-1:0] s;
        s = v >> 1;
        return s[0];
    endfunction

    // Register 0 is invisible to the tracker when it is hardwired to zero.
    function automatic logic is_x0(input logic [IW-1:0] idx);
        return (X0_ZERO != 0) && (idx == '0);
    endfunction

    // Next level state and error detection; flush wins over issue/commit.
    always_comb begin
        lvl_nxt = lvl;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        up_eff  = upgrade & ~is_x0(rd);
        dn_eff  = downgrade & ~is_x0(regwr_sel);
        if (flush) begin
            lvl_nxt = '0;
        end else if (!(up_eff && dn_eff && (rd == regwr_sel))) begin
            // A same-register issue and commit cancel out and are skipped above.
            if (up_eff) begin
                ovf_nxt     = lvl[rd][DEPTH-1];
                lvl_nxt[rd] = lvl_up(lvl[rd]);
            end
            if (dn_eff) begin
                unf_nxt            = ~lvl[regwr_sel][0];
                lvl_nxt[regwr_sel] = lvl_dn(lvl[regwr_sel]);
            end
        end
    end

    // Level state and one-cycle error pulses; reset discards everything at once.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            lvl           <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            lvl           <= lvl_nxt;
            err_overflow  <= ovf_nxt;
            err_underflow <= unf_nxt;
        end
    end

    // Read hazards and forwarding, judged on the current state only.
    always_comb begin
        haz1    = regrd_rs1_en & lvl[rs1][0] & ~is_x0(rs1);
        haz2    = regrd_rs2_en & lvl[rs2][0] & ~is_x0(rs2);
        fwd_rs1 = (FWD_EN != 0) & haz1 & ~lvl_deep(lvl[rs1]) & downgrade & (regwr_sel == rs1);
        fwd_rs2 = (FWD_EN != 0) & haz2 & ~lvl_deep(lvl[rs2]) & downgrade & (regwr_sel == rs2);
        stall   = (haz1 & ~fwd_rs1) | (haz2 & ~fwd_rs2);
    end

    // Any register with at least one write outstanding.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy[r] = lvl[r][0];
        end
        pending_any = |busy;
    end

endmodule

// File: tb/tb_kronos_hazard_tracker.sv
// tb_kronos_hazard_tracker: three tracker instances share one stimulus stream:
//   0: defaults (NREG=32, DEPTH=2, forwarding on, x0 hardwired)
//   1: defaults with forwarding disabled
//   2: NREG=8, DEPTH=1, forwarding on, register 0 tracked like any other
// A pending-write counter model per instance predicts every output each cycle.
module tb_kronos_hazard_tracker;

    localparam int NR  [3] = '{32, 32, 8};
    localparam int DP  [3] = '{2, 2, 1};
    localparam int FW  [3] = '{1, 0, 1};
    localparam int X0  [3] = '{1, 1, 0};

    logic       clk;
    logic       rstz;
    logic       flush;
    logic       upgrade;
    logic       downgrade;
    logic       e1;
    logic       e2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] sel;

    logic [2:0] stall_v;
    logic [2:0] fwd1_v;
    logic [2:0] fwd2_v;
    logic [2:0] pend_v;
    logic [2:0] ovf_v;
    logic [2:0] unf_v;

    int n_cmp;
    int n_fail;

    int cnt   [3][32];
    bit m_ovf [3];
    bit m_unf [3];

    kronos_hazard_tracker dut_a (
        .clk(clk), .rstz(rstz), .flush(flush),
        .rs1(rs1), .rs2(rs2), .regrd_rs1_en(e1), .regrd_rs2_en(e2),
        .rd(rd), .upgrade(upgrade), .regwr_sel(sel), .downgrade(downgrade),
        .stall(stall_v[0]), .fwd_rs1(fwd1_v[0]), .fwd_rs2(fwd2_v[0]),
        .pending_any(pend_v[0]), .err_overflow(ovf_v[0]), .err_underflow(unf_v[0])
    );

    kronos_hazard_tracker #(.FWD_EN(0)) dut_b (
        .clk(clk), .rstz(rstz), .flush(flush),
        .rs1(rs1), .rs2(rs2), .regrd_rs1_en(e1), .regrd_rs2_en(e2),
        .rd(rd), .upgrade(upgrade), .regwr_sel(sel), .downgrade(downgrade),
        .stall(stall_v[1]), .fwd_rs1(fwd1_v[1]), .fwd_rs2(fwd2_v[1]),
        .pending_any(pend_v[1]), .err_overflow(ovf_v[1]), .err_underflow(unf_v[1])
    );

    kronos_hazard_tracker #(.NREG(8), .DEPTH(1), .FWD_EN(1), .X0_ZERO(0)) dut_c (
        .clk(clk), .rstz(rstz), .flush(flush),
        .rs1(rs1[2:0]), .rs2(rs2[2:0]), .regrd_rs1_en(e1), .regrd_rs2_en(e2),
        .rd(rd[2:0]), .upgrade(upgrade), .regwr_sel(sel[2:0]), .downgrade(downgrade),
        .stall(stall_v[2]), .fwd_rs1(fwd1_v[2]), .fwd_rs2(fwd2_v[2]),
        .pending_any(pend_v[2]), .err_overflow(ovf_v[2]), .err_underflow(unf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count of in-flight writes per register, saturating at DEPTH.
    always @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < 3; i++) begin
                for (int r = 0; r < 32; r++) cnt[i][r] = 0;
                m_ovf[i] = 0;
                m_unf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  rdm;
                int  slm;
                bit  up;
                bit  dn;
                rdm = int'(rd) % NR[i];
                slm = int'(sel) % NR[i];
                up  = upgrade && !(X0[i] != 0 && rdm == 0);
                dn  = downgrade && !(X0[i] != 0 && slm == 0);
                m_ovf[i] = 0;
                m_unf[i] = 0;
                if (flush) begin
                    for (int r = 0; r < 32; r++) cnt[i][r] = 0;
                end else if (!(up && dn && rdm == slm)) begin
                    if (up) begin
                        if (cnt[i][rdm] == DP[i]) m_ovf[i] = 1;
                        else cnt[i][rdm]++;
                    end
                    if (dn) begin
                        if (cnt[i][slm] == 0) m_unf[i] = 1;
                        else cnt[i][slm]--;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int a;
            int b;
            int s;
            bit h1;
            bit h2;
            bit f1;
            bit f2;
            bit pe;
            a  = int'(rs1) % NR[i];
            b  = int'(rs2) % NR[i];
            s  = int'(sel) % NR[i];
            h1 = e1 && !(X0[i] != 0 && a == 0) && cnt[i][a] >= 1;
            h2 = e2 && !(X0[i] != 0 && b == 0) && cnt[i][b] >= 1;
            f1 = FW[i] != 0 && h1 && cnt[i][a] < 2 && downgrade && s == a;
            f2 = FW[i] != 0 && h2 && cnt[i][b] < 2 && downgrade && s == b;
            pe = 0;
            for (int r = 0; r < NR[i]; r++) if (cnt[i][r] > 0) pe = 1;
            check($sformatf("inst%0d stall", i), stall_v[i], (h1 && !f1) || (h2 && !f2));
            check($sformatf("inst%0d fwd_rs1", i), fwd1_v[i], f1);
            check($sformatf("inst%0d fwd_rs2", i), fwd2_v[i], f2);
            check($sformatf("inst%0d pending_any", i), pend_v[i], pe);
            check($sformatf("inst%0d err_overflow", i), ovf_v[i], m_ovf[i]);
            check($sformatf("inst%0d err_underflow", i), unf_v[i], m_unf[i]);
        end
    end

    // Drive one cycle of inputs just after a rising edge; return after the falling edge.
    task automatic apply(input bit up, input int rdv, input bit dn, input int slv,
                         input bit en1, input int r1v, input bit en2, input int r2v,
                         input bit fl);
        @(posedge clk);
        #1;
        upgrade   = up;
        rd        = rdv[4:0];
        downgrade = dn;
        sel       = slv[4:0];
        e1        = en1;
        rs1       = r1v[4:0];
        e2        = en2;
        rs2       = r2v[4:0];
        flush     = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rstz = 1'b1;
        flush = 0; upgrade = 0; downgrade = 0; e1 = 0; e2 = 0;
        rs1 = 0; rs2 = 0; rd = 0; sel = 0;
        #1 rstz = 1'b0;
        #22 rstz = 1'b1;
        idle();
        check("reset pending_any", pend_v[0], 1'b0);
        check("reset stall", stall_v[0], 1'b0);

        // Single write to x5, read it, then forward it on commit.
        apply(1, 5, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("x5 read stall", stall_v[0], 1'b1);
        check("x5 pending", pend_v[0], 1'b1);
        apply(0, 0, 1, 5, 1, 5, 0, 0, 0);
        check("x5 fwd_rs1", fwd1_v[0], 1'b1);
        check("x5 fwd no stall", stall_v[0], 1'b0);
        check("x5 nofwd stall", stall_v[1], 1'b1);
        check("x5 nofwd fwd_rs1", fwd1_v[1], 1'b0);
        idle();
        check("x5 drained pending", pend_v[0], 1'b0);

        // Two writes to x7: commit of the first cannot forward, the second can.
        apply(1, 7, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 7, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 7, 0, 0, 1, 7, 0);
        check("x7 level2 stall", stall_v[0], 1'b1);
        check("x7 level2 fwd_rs2", fwd2_v[0], 1'b0);
        apply(0, 0, 1, 7, 0, 0, 1, 7, 0);
        check("x7 level1 stall", stall_v[0], 1'b0);
        check("x7 level1 fwd_rs2", fwd2_v[0], 1'b1);
        idle();

        // Overflow on x3, underflow on idle x9.
        apply(1, 3, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 3, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 3, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 3, 1, 3, 0, 0, 0);
        check("x3 overflow pulse", ovf_v[0], 1'b1);
        check("x3 saturated stall", stall_v[0], 1'b1);
        apply(0, 0, 1, 3, 1, 3, 0, 0, 0);
        check("x3 overflow single", ovf_v[0], 1'b0);
        check("x3 last fwd", fwd1_v[0], 1'b1);
        apply(0, 0, 1, 9, 0, 0, 0, 0, 0);
        idle();
        check("x9 underflow pulse", unf_v[0], 1'b1);
        check("x9 no pending", pend_v[0], 1'b0);

        // Same-register issue/commit cancels; different registers both apply.
        apply(1, 4, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 4, 1, 4, 0, 0, 0, 0, 0);
        apply(1, 4, 1, 6, 1, 4, 0, 0, 0);
        check("x4 cancel level1 fwd", fwd1_v[0], 1'b0);
        check("x4 cancel no err", unf_v[0] | ovf_v[0], 1'b0);
        apply(0, 0, 1, 4, 1, 4, 1, 6, 0);
        check("x6 underflow pulse", unf_v[0], 1'b1);
        check("x4 level2 stall", stall_v[0], 1'b1);
        apply(0, 0, 1, 4, 0, 0, 0, 0, 0);
        idle();
        check("x4 drained", pend_v[0], 1'b0);

        // Flush clears everything; x0 is never tracked.
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 2, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 31, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 8, 0, 0, 1, 1, 0, 0, 1);
        check("flush cycle stall", stall_v[0], 1'b1);
        idle();
        check("flush pending", pend_v[0], 1'b0);
        check("flush no ovf", ovf_v[0], 1'b0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 1, 0, 1, 0, 0);
        check("x0 no stall", stall_v[0], 1'b0);
        check("x0 no pending", pend_v[0], 1'b0);
        idle();
        check("x0 no underflow", unf_v[0], 1'b0);

        // Asynchronous reset in the middle of a stalled read.
        apply(1, 5, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("pre-reset stall", stall_v[0], 1'b1);
        #1 rstz = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async rst inst%0d outputs", i),
                  stall_v[i] | fwd1_v[i] | fwd2_v[i] | pend_v[i] | ovf_v[i] | unf_v[i], 1'b0);
        end
        @(posedge clk);
        #3 rstz = 1'b1;
        idle();
        check("post-reset no err", ovf_v[0] | unf_v[0], 1'b0);
        check("post-reset pending", pend_v[0], 1'b0);

        // Pseudo-random traffic over a few registers to hit saturation corners.
        for (int k = 0; k < 300; k++) begin
            apply(1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  ($urandom_range(0, 15) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
